// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data memory stage.
// Optional parity storage is enabled with the DMEM_PARITY_EN macro.
package dmem_pkg;

  // MemSize encodings; 2'b11 decodes as a word access
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Byte lanes touched by an access of the given size at the given low address bits
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << lo;
      SZ_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Even parity bit per byte lane
  function automatic logic [3:0] byte_parity(input logic [31:0] w);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) begin
      p[i] = ^w[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/data_memory_load_extend.sv
// Load lane selection plus sign/zero extension for the data memory stage.
module load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane(s), then extend to 32 bits
  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    case (i_size)
      SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Data memory stage: byte/half/word loads and stores with alignment checks and a
// sequential zero-clear after every reset (Busy stalls the core meanwhile).
// Define DMEM_PARITY_EN to add per-byte even parity and the ParityErr output.
module data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  MemSize,
  input  logic        LoadUnsigned,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Misaligned,
`ifdef DMEM_PARITY_EN
  output logic        ParityErr,
`endif
  output logic        Busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e          r_state;
  logic [AW-1:0]   r_cnt;
  logic [31:0]     r_mem [DEPTH];

  logic            w_busy;
  logic [AW-1:0]   w_idx;
  logic            w_mis_raw;
  logic            w_store;
  logic            w_load;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [31:0]     w_word;
  logic [31:0]     w_ext;
  logic            w_unused_addr;

  // Busy covers both the reset itself and the clear sweep that follows it
  assign w_busy        = rst | (r_state == ST_CLEAR);
  assign Busy          = w_busy;
  assign w_idx         = ALUResult[AW+1:2];
  assign w_unused_addr = ^ALUResult[31:AW+2];
  assign w_word        = r_mem[w_idx];
  assign w_be          = lane_mask(MemSize, ALUResult[1:0]);

  // Alignment decode and request qualification
  always_comb begin
    case (MemSize)
      SZ_BYTE: w_mis_raw = 1'b0;
      SZ_HALF: w_mis_raw = ALUResult[0];
      default: w_mis_raw = |ALUResult[1:0];
    endcase
    Misaligned = (MemRead | MemWrite) & ~w_busy & w_mis_raw;
    w_store    = MemWrite & ~w_busy & ~w_mis_raw;
    w_load     = MemRead & ~w_busy & ~w_mis_raw;
  end

  // Replicate narrow store data across lanes so any enabled lane sees the right bits
  always_comb begin
    case (MemSize)
      SZ_BYTE: w_wdata = {4{WriteData[7:0]}};
      SZ_HALF: w_wdata = {2{WriteData[15:0]}};
      default: w_wdata = WriteData;
    endcase
  end

  // Clear-sweep FSM: restart from word 0 on every reset, ready after the last word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_cnt <= r_cnt + AW'(1);
      if (r_cnt == AW'(DEPTH - 1)) begin
        r_state <= ST_READY;
      end
    end
  end

  // Storage array: zero one word per cycle while clearing, else lane-masked stores
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_cnt] <= '0;
      end else if (w_store) begin
        for (int i = 0; i < 4; i++) begin
          if (w_be[i]) begin
            r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  load_extend u_load_extend (
    .i_word     (w_word),
    .i_addr_lo  (ALUResult[1:0]),
    .i_size     (MemSize),
    .i_unsigned (LoadUnsigned),
    .o_data     (w_ext)
  );

  assign ReadData = w_load ? w_ext : 32'h0;

`ifdef DMEM_PARITY_EN
  logic [3:0] r_par [DEPTH];
  logic [3:0] w_par_bad;

  // Parity array tracks the data array lane for lane
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        r_par[r_cnt] <= 4'h0;
      end else if (w_store) begin
        for (int i = 0; i < 4; i++) begin
          if (w_be[i]) begin
            r_par[w_idx][i] <= ^w_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  assign w_par_bad = r_par[w_idx] ^ byte_parity(w_word);
  assign ParityErr = w_load & |(w_par_bad & w_be);
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: reference memory model plus a scoreboard
// queue of expected outputs, popped when the DUT outputs are sampled.
module tb_data_memory;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  MemSize;
  logic        LoadUnsigned;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Misaligned;
  logic        Busy;
`ifdef DMEM_PARITY_EN
  logic        ParityErr;
`endif

  always #5 clk = ~clk;

  data_memory #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .MemSize      (MemSize),
    .LoadUnsigned (LoadUnsigned),
    .ALUResult    (ALUResult),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .Misaligned   (Misaligned),
`ifdef DMEM_PARITY_EN
    .ParityErr    (ParityErr),
`endif
    .Busy         (Busy)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] sb [$];
  logic [31:0] ref_mem [DEPTH];
  logic        exp_perr = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic model_mis(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b00) return 1'b0;
    if (size == 2'b01) return addr[0];
    return addr[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = ref_mem[addr[7:2]];
    b = 8'(w >> {addr[1:0], 3'b000});
    h = addr[1] ? w[31:16] : w[15:0];
    if (size == 2'b00) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (size == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return w;
  endfunction

  function automatic void model_store(input logic [1:0] size, input logic [31:0] addr,
                                      input logic [31:0] d);
    logic [31:0] w;
    w = ref_mem[addr[7:2]];
    if (size == 2'b00) w[{addr[1:0], 3'b000} +: 8] = d[7:0];
    else if (size == 2'b01) w[{addr[1], 4'b0000} +: 16] = d[15:0];
    else w = d;
    ref_mem[addr[7:2]] = w;
  endfunction

  // One request: drive after a rising edge, sample at the falling edge
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic mis;
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; MemSize = size; LoadUnsigned = uns;
    ALUResult = addr; WriteData = wdata;
    mis = (rd | wr) & model_mis(size, addr);
    sb.push_back((rd && !mis) ? model_load(size, uns, addr) : 32'h0);
    sb.push_back({31'b0, mis});
    @(negedge clk);
    check_eq({tag, "/rdata"}, ReadData, sb.pop_front());
    check_eq({tag, "/misal"}, {31'b0, Misaligned}, sb.pop_front());
`ifdef DMEM_PARITY_EN
    check_eq({tag, "/perr"}, {31'b0, ParityErr}, {31'b0, exp_perr & rd & ~mis});
`endif
    if (wr && !mis) model_store(size, addr, wdata);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  // Counts falling edges with Busy high, bounded so a stuck Busy cannot hang the run
  task automatic count_busy(input string tag);
    int n;
    n = 0;
    sb.push_back(32'(DEPTH));
    for (int i = 0; i < 4 * DEPTH; i++) begin
      @(negedge clk);
      if (!Busy) break;
      n++;
      if (n == 10) begin
        MemWrite = 1'b1; MemSize = SZ_WORD; ALUResult = 32'h4; WriteData = 32'h0000_1234;
      end else if (n == 11) begin
        MemWrite = 1'b0;
        MemRead = 1'b1; ALUResult = 32'h6;
      end else if (n == 12) begin
        check_eq({tag, "/busy_misal"}, {31'b0, Misaligned}, 32'h0);
        ALUResult = 32'h10;
      end else if (n == 13) begin
        check_eq({tag, "/busy_rdata"}, ReadData, 32'h0);
        MemRead = 1'b0;
      end
    end
    check_eq({tag, "/len"}, 32'(n), sb.pop_front());
  endtask

  initial begin
    rst = 1'b1; MemWrite = 1'b0; MemRead = 1'b1; MemSize = SZ_WORD; LoadUnsigned = 1'b0;
    ALUResult = 32'h11; WriteData = 32'h0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst/busy", {31'b0, Busy}, 32'h1);
    check_eq("rst/rdata", ReadData, 32'h0);
    check_eq("rst/misal", {31'b0, Misaligned}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; MemRead = 1'b0;
    count_busy("clear1");

    // Store attempted during the clear must not have landed
    access("after_clear_w4", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0);
    access("after_clear_w10", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);

    // Lane extraction
    access("st_deadbeef", 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h8, 32'hDEAD_BEEF);
    access("ld_w8", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0);
    access("ld_b_b_s", 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'hB, 32'h0);
    access("ld_b_b_u", 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'hB, 32'h0);
    access("ld_h_a_s", 1'b1, 1'b0, SZ_HALF, 1'b0, 32'hA, 32'h0);
    access("ld_h_8_s", 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h8, 32'h0);
    access("ld_h_a_u", 1'b1, 1'b0, SZ_HALF, 1'b1, 32'hA, 32'h0);
    access("ld_sz3_8", 1'b1, 1'b0, 2'b11, 1'b1, 32'h8, 32'h0);

    // Partial store keeps other lanes
    access("st_b_9", 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h9, 32'h1234_565A);
    access("ld_w8_part", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0);
    access("st_h_e", 1'b0, 1'b1, SZ_HALF, 1'b0, 32'hE, 32'hFFFF_8001);
    access("ld_w_c", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'hC, 32'h0);

    // Alignment faults
    access("st_w_6_mis", 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h6, 32'hCAFE_F00D);
    access("ld_w4_unch", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0);
    access("ld_h_3_mis", 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h3, 32'h0);
    access("ld_b_3_ok", 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h3, 32'h0);

    // Address wrap
    access("st_w_100", 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h100, 32'h1122_3344);
    access("ld_w_0", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);

    // Simultaneous read/write shows pre-edge data
    access("rw_w_0", 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h0, 32'hA5A5_0F0F);
    access("ld_w_0_new", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);

`ifdef DMEM_PARITY_EN
    access("par_ok", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0);
    dut.r_mem[2][8] = ~dut.r_mem[2][8];
    ref_mem[2][8]   = ~ref_mem[2][8];
    exp_perr = 1'b1;
    access("par_bad_b9", 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h9, 32'h0);
    exp_perr = 1'b0;
    access("par_ok_b8", 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h8, 32'h0);
`endif
    idle();

    // Reset mid-clear restarts the full sweep
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("rst2/busy", {31'b0, Busy}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    count_busy("clear2");
    access("clr2_w8", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0);
    access("clr2_w0", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    access("clr2_w4", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
